// File: rtl/regfile_read_port_if.sv
// Request/response bus between the control unit and the register-file read port.
// The control unit drives the request side and consumes the response side.
interface regfile_read_port_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_sr1;
  logic [2:0]            req_sr2;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_sr1_data;
  logic [DATA_WIDTH-1:0] rsp_sr2_data;

  modport master (
    output req_valid, req_sr1, req_sr2, rsp_ready,
    input  req_ready, rsp_valid, rsp_sr1_data, rsp_sr2_data
  );

  modport slave (
    input  req_valid, req_sr1, req_sr2, rsp_ready,
    output req_ready, rsp_valid, rsp_sr1_data, rsp_sr2_data
  );
endinterface

// File: rtl/regfile_read_port.sv
// Read-side companion of the eight-entry LC-3 register file.
// Accepts two-source read requests and returns both operands through a
// 2-entry registered response buffer (circular head/tail, count 0..2).
// Optional feature macro: REGREAD_BYPASS_EN -- when defined, register writes
// are forwarded into captured and queued operands so they never go stale.
module regfile_read_port #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] reg1_in,
  input  logic [DATA_WIDTH-1:0] reg2_in,
  input  logic [DATA_WIDTH-1:0] reg3_in,
  input  logic [DATA_WIDTH-1:0] reg4_in,
  input  logic [DATA_WIDTH-1:0] reg5_in,
  input  logic [DATA_WIDTH-1:0] reg6_in,
  input  logic [DATA_WIDTH-1:0] reg7_in,
  input  logic [DATA_WIDTH-1:0] reg8_in,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [7:0]            ld_reg,
  input  logic                  clr_err,
  output logic                  ld_err,
  regfile_read_port_if.slave    bus
);

  // More than one write enable active in the same cycle.
  function automatic logic multi_hot(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

  logic [DATA_WIDTH-1:0] regs_s [8];
  logic [DATA_WIDTH-1:0] sr1_data_r [2];
  logic [DATA_WIDTH-1:0] sr2_data_r [2];
  logic [DATA_WIDTH-1:0] cap1_s;
  logic [DATA_WIDTH-1:0] cap2_s;
  logic [1:0]            count_r;
  logic                  head_r;
  logic                  tail_r;
  logic                  push_s;
  logic                  pop_s;

  assign regs_s[0] = reg1_in;
  assign regs_s[1] = reg2_in;
  assign regs_s[2] = reg3_in;
  assign regs_s[3] = reg4_in;
  assign regs_s[4] = reg5_in;
  assign regs_s[5] = reg6_in;
  assign regs_s[6] = reg7_in;
  assign regs_s[7] = reg8_in;

  // Ready depends on occupancy only: no pass-through when the buffer is full.
  assign bus.req_ready    = (count_r != 2'd2);
  assign bus.rsp_valid    = (count_r != 2'd0);
  assign bus.rsp_sr1_data = sr1_data_r[head_r];
  assign bus.rsp_sr2_data = sr2_data_r[head_r];

  assign push_s = bus.req_valid & bus.req_ready;
  assign pop_s  = bus.rsp_valid & bus.rsp_ready;

`ifdef REGREAD_BYPASS_EN
  logic [2:0] sr1_idx_r [2];
  logic [2:0] sr2_idx_r [2];
  logic [1:0] occ_s;

  // Which entries currently hold a live operand pair.
  always_comb begin
    occ_s    = 2'b00;
    occ_s[0] = (count_r == 2'd2) || ((count_r == 2'd1) && !head_r);
    occ_s[1] = (count_r == 2'd2) || ((count_r == 2'd1) && head_r);
  end

  // Capture value: a register written this cycle is taken from the write bus.
  always_comb begin
    cap1_s = regs_s[bus.req_sr1];
    cap2_s = regs_s[bus.req_sr2];
    if (ld_reg[bus.req_sr1]) begin
      cap1_s = wr_data;
    end else begin
      cap1_s = regs_s[bus.req_sr1];
    end
    if (ld_reg[bus.req_sr2]) begin
      cap2_s = wr_data;
    end else begin
      cap2_s = regs_s[bus.req_sr2];
    end
  end

  // Entry storage: refresh live entries on matching writes, then fill the tail.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        sr1_idx_r[i]  <= 3'd0;
        sr2_idx_r[i]  <= 3'd0;
        sr1_data_r[i] <= '0;
        sr2_data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (occ_s[i] && ld_reg[sr1_idx_r[i]]) sr1_data_r[i] <= wr_data;
        if (occ_s[i] && ld_reg[sr2_idx_r[i]]) sr2_data_r[i] <= wr_data;
      end
      if (push_s) begin
        sr1_idx_r[tail_r]  <= bus.req_sr1;
        sr2_idx_r[tail_r]  <= bus.req_sr2;
        sr1_data_r[tail_r] <= cap1_s;
        sr2_data_r[tail_r] <= cap2_s;
      end
    end
  end
`else
  logic unused_s;
  assign unused_s = ^wr_data;

  // Capture value: pre-write register outputs as sampled at the accept edge.
  always_comb begin
    cap1_s = regs_s[bus.req_sr1];
    cap2_s = regs_s[bus.req_sr2];
  end

  // Entry storage: written once on accept, never modified afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        sr1_data_r[i] <= '0;
        sr2_data_r[i] <= '0;
      end
    end else if (push_s) begin
      sr1_data_r[tail_r] <= cap1_s;
      sr2_data_r[tail_r] <= cap2_s;
    end
  end
`endif

  // Occupancy and circular pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= 2'd0;
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
    end else begin
      if (push_s) tail_r <= ~tail_r;
      if (pop_s)  head_r <= ~head_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky multi-write error; a new error wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_err <= 1'b0;
    end else if (multi_hot(ld_reg)) begin
      ld_err <= 1'b1;
    end else if (clr_err) begin
      ld_err <= 1'b0;
    end
  end

endmodule
